counter_mode_controller: RTL

Control stage directly upstream of the 10-bit universal counter. Turns StartStop/Load button pulses and a Direction switch into the counter's mode pins {S1,S0} and parallel-load value P. A prescaler paces count steps to one per DIVISOR clocks. The block watches the counter's TerminalCount to count wrap-arounds and, optionally, to stop after a wrap.

---
 rtl/counter_mode_controller_pkg.sv | 21 ++
 rtl/counter_mode_controller_if.sv | 28 ++
 rtl/counter_mode_controller_sync_edge_detect.sv | 30 +++
 rtl/counter_mode_controller.sv | 132 +++++++++++++
 4 files changed

// File: rtl/counter_mode_controller_pkg.sv
// Shared encodings for the counter mode controller: FSM states and the
// {S1,S0} mode codes understood by the downstream universal counter.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // A step cycle is any cycle in which the counter actually moves.
  function automatic logic is_step(input logic [1:0] mode);
    return (mode == MODE_UP) || (mode == MODE_DOWN);
  endfunction

endpackage

// File: rtl/counter_mode_controller_if.sv
// Button/switch inputs and counter-facing outputs of the mode controller.
// master = controller side, slave = buttons plus the counter.
interface counter_mode_controller_if #(
  parameter int length = 10,
  parameter int WRAPW  = 8
);
  logic              StartStop;
  logic              Load;
  logic              Direction;
  logic              OneShot;
  logic [length-1:0] LoadValue;
  logic              TerminalCount;
  logic              S1;
  logic              S0;
  logic [length-1:0] P;
  logic              Running;
  logic [WRAPW-1:0]  WrapCount;

  modport master (
    input  StartStop, Load, Direction, OneShot, LoadValue, TerminalCount,
    output S1, S0, P, Running, WrapCount
  );

  modport slave (
    output StartStop, Load, Direction, OneShot, LoadValue, TerminalCount,
    input  S1, S0, P, Running, WrapCount
  );
endinterface

// File: rtl/counter_mode_controller_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input, with its synchronized
// level and a one-cycle pulse on each rising edge of that level.
module sync_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic async_i,
  output logic level_o,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic sync2_dly_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync2_dly_q <= 1'b0;
    end else begin
      sync1_q     <= async_i;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign pulse_o = sync2_q & ~sync2_dly_q;

endmodule

// File: rtl/counter_mode_controller.sv
// Mode controller upstream of the 10-bit universal counter: run/idle/load FSM,
// step prescaler and saturating wrap-around counter.
module counter_mode_controller
  import counter_ctrl_pkg::*;
#(
  parameter int length  = 10,
  parameter int DIVISOR = 4,
  parameter int WRAPW   = 8
) (
  input logic CLK,
  input logic RESET,
  counter_mode_controller_if.master ctl
);

  localparam int                   PRESC_W    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(DIVISOR - 1);
  localparam logic [WRAPW-1:0]     WRAP_MAX   = '1;

  // Bit 0 = StartStop, bit 1 = Load, bit 2 = Direction.
  logic [2:0] async_vec;
  logic [2:0] level_vec;
  logic [2:0] pulse_vec;
  logic       sync_unused;

  assign async_vec = {ctl.Direction, ctl.Load, ctl.StartStop};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync_edge_detect u_sync (
        .CLK     (CLK),
        .RESET   (RESET),
        .async_i (async_vec[gi]),
        .level_o (level_vec[gi]),
        .pulse_o (pulse_vec[gi])
      );
    end
  endgenerate

  logic ss_edge;
  logic ld_edge;
  logic dir_down;

  assign ss_edge     = pulse_vec[0];
  assign ld_edge     = pulse_vec[1];
  assign dir_down    = level_vec[2];
  assign sync_unused = ^{level_vec[1:0], pulse_vec[2]};

  state_e             state_q, state_d;
  state_e             ret_q, ret_d;
  state_e             settled;
  state_e             target;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]         mode_q, mode_d;
  logic [length-1:0]  p_q, p_d;
  logic               running_q, running_d;
  logic [WRAPW-1:0]   wrap_q, wrap_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      presc_q   <= '0;
      mode_q    <= MODE_HOLD;
      p_q       <= '0;
      running_q <= 1'b0;
      wrap_q    <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      p_q       <= p_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    presc_d   = presc_q;
    mode_d    = MODE_HOLD;
    p_d       = p_q;
    wrap_d    = wrap_q;
    running_d = 1'b0;

    // LOAD is transparent: decisions are taken against where it will return.
    settled = (state_q == ST_LOAD) ? ret_q : state_q;
    target  = settled;
    if (ss_edge) begin
      target = (settled == ST_RUN) ? ST_IDLE : ST_RUN;
    end

    if (is_step(mode_q) && ctl.TerminalCount) begin
      if (wrap_q != WRAP_MAX) begin
        wrap_d = wrap_q + WRAPW'(1);
      end
      if (ctl.OneShot) begin
        target = ST_IDLE;
      end
    end

    if (ld_edge) begin
      state_d = ST_LOAD;
      ret_d   = target;
      mode_d  = MODE_LOAD;
      p_d     = ctl.LoadValue;
      presc_d = '0;
    end else begin
      state_d = target;
      if (target == ST_RUN && state_q == ST_RUN) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          mode_d  = dir_down ? MODE_DOWN : MODE_UP;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end else if (target == ST_RUN) begin
        presc_d = '0;
      end
    end

    running_d = (state_d == ST_RUN) || (state_d == ST_LOAD && ret_d == ST_RUN);
  end

  assign ctl.S1        = mode_q[1];
  assign ctl.S0        = mode_q[0];
  assign ctl.P         = p_q;
  assign ctl.Running   = running_q;
  assign ctl.WrapCount = wrap_q;

endmodule
